interp_sequencer: RTL and testbench
===================================

INTERP_SEQUENCER -- requirements
Module: interp_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, 10, BRAM address width; DATA_W, 16, signed sample width; UP_SHIFT, 2, log2 of upsample factor L (L=4).
REQ-002 CLK100MHZ  in  1  single clock; all logic on its rising edge.
REQ-003 reset  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  one-cycle request pulse from the top-level FSM.
REQ-005 abort  in  1  cancels the run in progress.
REQ-006 mode  in  2  00 lin, 01 poly, 10 spline, 11 reserved.
REQ-007 n_points  in  ADDR_W  number of input samples to process.
REQ-008 in_en, in_addr  out  1, ADDR_W  input-BRAM read port controls.
REQ-009 in_rdata  in  DATA_W  input-BRAM read data, valid the cycle after the address is sampled.
REQ-010 out_we, out_addr, out_wdata  out  1, ADDR_W, DATA_W  output-BRAM write port.
REQ-011 busy, done, err  out  1 each  status: busy level, done pulse, err pulse.

Function
REQ-012 States SHALL be IDLE, FETCH0, WAIT0, FETCH, WAIT, INTERP, LAST, DONE.
REQ-013 IDLE: start=1 with mode=lin and 2<=n_points<=256 SHALL latch mode/n_points and go to FETCH0; any other start SHALL pulse err for 1 cycle and stay IDLE.
REQ-014 FETCH0: in_en=1, in_addr=0; WAIT0: capture in_rdata as a, seg index i=0.
REQ-015 FETCH: in_en=1, in_addr=i+1; WAIT: capture in_rdata as b, j=0.
REQ-016 INTERP: one write per cycle for j=0..L-1: out_we=1, out_addr=i*L+j, out_wdata=a+(((b-a)*j)>>>UP_SHIFT).
REQ-017 Arithmetic: b-a computed DATA_W+1 bits signed; product DATA_W+1+UP_SHIFT bits signed; arithmetic right shift (floor); sum truncated to DATA_W; result always lies between a and b, so no overflow.
REQ-018 After j=L-1: a<=b, i<=i+1; go to FETCH if i+1<n_points-1, else LAST.
REQ-019 LAST: write out_addr=(n_points-1)*L, out_wdata=b; then DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 Total outputs written = (n_points-1)*L+1; done SHALL be high in cycle 6*n_points-2 counted from the start-sampling edge.
REQ-022 busy=1 in every state except IDLE; start while busy SHALL be ignored (no err).
REQ-023 abort in any non-IDLE state SHALL force IDLE on the next edge: no further writes, no done; abort has priority over the state transition of that cycle.
REQ-024 out_we and in_en SHALL be 0 in every state not listed above; out_we and in_en are never high in the same cycle.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On reset=1 at a clock edge: state IDLE; busy, done, err, in_en, out_we = 0; in_addr, out_addr, out_wdata = 0; a, b, i, j cleared.
REQ-027 reset SHALL override start and abort; reset mid-run SHALL abandon the run with no done pulse.

Structure
REQ-028 Package interp_pkg SHALL hold the mode encodings (lin/poly/spline), state encoding, ADDR_W, DATA_W and UP_SHIFT defaults.
REQ-029 Sub-module lin_interp_core SHALL implement REQ-016/017 combinationally (inputs a, b, j; output sample); the sequencer registers its result.

Verification
REQ-030 n_points=2, in[0]=0, in[1]=100, start -> writes addr 0..4 = 0,25,50,75,100; done in cycle 10; busy low after.
REQ-031 n_points=3, in={-8,8,-8} -> 9 writes: -8,-4,0,4,8,4,0,-4,-8 at addr 0..8.
REQ-032 start with mode=poly, or n_points=1 or 257 -> err pulse 1 cycle, no writes, busy stays 0.
REQ-033 in={32767,-32768}, n_points=2 -> 32767,16383,-1,-16385,-32768; no wrap.
REQ-034 abort asserted in INTERP at j=1 -> no further out_we, no done, IDLE next cycle; new start then runs normally.
REQ-035 reset during WAIT, then start pulse asserted while busy -> outputs at REQ-026 values; the pulse while busy causes no err and no restart.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared encodings and default widths for the linear-interpolation sequencer.
// Holds the mode codes, the FSM state encoding and the accepted run lengths.
package interp_pkg;

    localparam int ADDR_W_DEFAULT   = 10;
    localparam int DATA_W_DEFAULT   = 16;
    localparam int UP_SHIFT_DEFAULT = 2;

    localparam int MIN_POINTS = 2;
    localparam int MAX_POINTS = 256;

    typedef enum logic [1:0] {
        MODE_LIN    = 2'b00,
        MODE_POLY   = 2'b01,
        MODE_SPLINE = 2'b10
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        WAIT0,
        FETCH,
        WAIT,
        INTERP,
        LAST,
        DONE
    } state_e;

endpackage

// File: rtl/lin_interp_core.sv
// Combinational linear interpolator: sample = a + floor(((b - a) * j) / 2**UP_SHIFT).
// The result always lies between a and b, so truncating the sum back to DATA_W never wraps.
module lin_interp_core
    import interp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int UP_SHIFT = UP_SHIFT_DEFAULT
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    input  logic        [UP_SHIFT-1:0] j,
    output logic signed [DATA_W-1:0]   sample
);

    localparam int PROD_W = DATA_W + 1 + UP_SHIFT;

    function automatic logic signed [PROD_W-1:0] floor_shift(input logic signed [PROD_W-1:0] x);
        return x >>> UP_SHIFT;
    endfunction

    function automatic logic signed [DATA_W-1:0] trunc_sum(input logic signed [PROD_W-1:0] x);
        return x[DATA_W-1:0];
    endfunction

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] j_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;

    always_comb begin
        diff   = (DATA_W+1)'(b) - (DATA_W+1)'(a);
        diff_x = PROD_W'(diff);
        j_x    = PROD_W'({1'b0, j});
        prod   = diff_x * j_x;
        sum    = PROD_W'(a) + floor_shift(prod);
        sample = trunc_sum(sum);
    end

endmodule

// File: rtl/interp_sequencer.sv
// Reads n_points samples from the input BRAM and writes the L-times upsampled
// linear interpolation to the output BRAM; every output is a register.
module interp_sequencer
    import interp_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int UP_SHIFT = UP_SHIFT_DEFAULT
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic        [1:0]        mode,
    input  logic        [ADDR_W-1:0] n_points,
    output logic                     in_en,
    output logic        [ADDR_W-1:0] in_addr,
    input  logic signed [DATA_W-1:0] in_rdata,
    output logic                     out_we,
    output logic        [ADDR_W-1:0] out_addr,
    output logic signed [DATA_W-1:0] out_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [UP_SHIFT-1:0] J_LAST = '1;

    state_e                   state, state_next;
    logic signed [DATA_W-1:0] a_reg, a_next, b_reg, b_next;
    logic        [ADDR_W-1:0] i_reg, i_next, n_reg, n_next;
    logic      [UP_SHIFT-1:0] j_reg, j_next;
    logic        [1:0]        mode_reg, mode_next;
    logic                     start_ok, err_next;
    logic signed [DATA_W-1:0] sample;

    logic                     in_en_next, out_we_next;
    logic        [ADDR_W-1:0] in_addr_next, out_addr_next;
    logic signed [DATA_W-1:0] out_wdata_next;

    lin_interp_core #(
        .DATA_W  (DATA_W),
        .UP_SHIFT(UP_SHIFT)
    ) u_core (
        .a     (a_next),
        .b     (b_next),
        .j     (j_next),
        .sample(sample)
    );

    assign start_ok = (mode == MODE_LIN)
                   && (n_points >= ADDR_W'(MIN_POINTS))
                   && (n_points <= ADDR_W'(MAX_POINTS));

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        n_next     = n_reg;
        mode_next  = mode_reg;
        err_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_next = FETCH0;
                        n_next     = n_points;
                        mode_next  = mode;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            FETCH0: state_next = WAIT0;
            WAIT0: begin
                a_next     = in_rdata;
                i_next     = '0;
                state_next = FETCH;
            end
            FETCH: state_next = WAIT;
            WAIT: begin
                b_next     = in_rdata;
                j_next     = '0;
                state_next = INTERP;
            end
            INTERP: begin
                j_next = j_reg + UP_SHIFT'(1);
                if (j_reg == J_LAST) begin
                    a_next     = b_reg;
                    i_next     = i_reg + ADDR_W'(1);
                    state_next = (i_reg + ADDR_W'(1) < n_reg - ADDR_W'(1)) ? FETCH : LAST;
                end
            end
            LAST:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort wins over whatever transition the current state asked for.
        if (abort && state != IDLE) begin
            state_next = IDLE;
        end
    end

    // Outputs are decoded from the next state so the registered values line up with it.
    always_comb begin
        in_en_next     = (state_next == FETCH0) || (state_next == FETCH);
        in_addr_next   = (state_next == FETCH) ? i_next + ADDR_W'(1) : '0;
        out_we_next    = 1'b0;
        out_addr_next  = '0;
        out_wdata_next = '0;
        if (state_next == INTERP && mode_next == MODE_LIN) begin
            out_we_next    = 1'b1;
            out_addr_next  = (i_next << UP_SHIFT) | ADDR_W'(j_next);
            out_wdata_next = sample;
        end else if (state_next == LAST) begin
            out_we_next    = 1'b1;
            out_addr_next  = (n_next - ADDR_W'(1)) << UP_SHIFT;
            out_wdata_next = b_next;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            n_reg     <= '0;
            mode_reg  <= '0;
            in_en     <= 1'b0;
            in_addr   <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            n_reg     <= n_next;
            mode_reg  <= mode_next;
            in_en     <= in_en_next;
            in_addr   <= in_addr_next;
            out_we    <= out_we_next;
            out_addr  <= out_addr_next;
            out_wdata <= out_wdata_next;
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_interp_sequencer.sv
// Self-checking bench for interp_sequencer: BRAM read model, write scoreboard, scenario tasks.
module tb_interp_sequencer;

    localparam int AW = 10;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset, start, abort;
    logic        [1:0]    mode;
    logic        [AW-1:0] n_points;
    logic                 in_en, out_we, busy, done, err;
    logic        [AW-1:0] in_addr, out_addr;
    logic signed [DW-1:0] in_rdata, out_wdata;

    logic signed [DW-1:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc, done_cnt, done_cyc, err_cnt, overlap, busy_seen;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] got_q[$];

    interp_sequencer dut (
        .CLK100MHZ(clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .n_points (n_points),
        .in_en    (in_en),
        .in_addr  (in_addr),
        .in_rdata (in_rdata),
        .out_we   (out_we),
        .out_addr (out_addr),
        .out_wdata(out_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_en) in_rdata <= mem[in_addr];
    end

    // Advance one clock and record what the DUT did in that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (out_we) got_q.push_back({out_addr, out_wdata});
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (err) err_cnt++;
        if (busy) busy_seen++;
        if (out_we && in_en) overlap++;
    endtask

    task automatic clear_obs();
        got_q.delete();
        cyc = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; overlap = 0; busy_seen = 0;
    endtask

    task automatic push_exp(input int addr, input int val);
        exp_q.push_back({AW'(addr), DW'(val)});
    endtask

    function automatic int model(input int a, input int b, input int j);
        int d, q;
        d = (b - a) * j;
        q = d / 4;
        if (d < 0 && (d % 4) != 0) q = q - 1;
        return a + q;
    endfunction

    task automatic build_expected(input int n);
        exp_q.delete();
        for (int i = 0; i < n - 1; i++)
            for (int j = 0; j < 4; j++)
                push_exp(i * 4 + j, model(int'(mem[i]), int'(mem[i+1]), j));
        push_exp((n - 1) * 4, int'(mem[n-1]));
    endtask

    // Full run of n points; optionally pulses a (bad-mode) start while busy at cycle poke.
    task automatic test_run(input string name, input int n, input int poke);
        int m;
        clear_obs();
        mode = 2'b00; n_points = AW'(n); start = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == 0 && cyc < 6 * n + 20) begin
            if (cyc == poke) begin start = 1'b1; mode = 2'b01; end
            tick();
            start = 1'b0; mode = 2'b00;
        end
        tick(); tick();
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt); end
        checks++;
        if (done_cyc !== 6 * n - 2) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, 6 * n - 2); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL %s write_count: got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < m; k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s write%0d: got addr=%0d data=%0d want addr=%0d data=%0d", name, k,
                         got_q[k][AW+DW-1:DW], $signed(got_q[k][DW-1:0]),
                         exp_q[k][AW+DW-1:DW], $signed(exp_q[k][DW-1:0]));
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after: got %b want 0", name, busy); end
        checks++;
        if (err_cnt !== 0) begin errors++; $display("FAIL %s err_count: got %0d want 0", name, err_cnt); end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL %s en_we_overlap: got %0d want 0", name, overlap); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; n_points = '0;
        clear_obs();
        tick(); tick(); tick();
        checks++;
        if ({busy, done, err, in_en, out_we, in_addr, out_addr, out_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b in_en=%b we=%b ia=%0d oa=%0d wd=%0d want all 0",
                     busy, done, err, in_en, out_we, in_addr, out_addr, out_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        mem[0] = 16'sd0; mem[1] = 16'sd100;
        exp_q.delete();
        push_exp(0, 0); push_exp(1, 25); push_exp(2, 50); push_exp(3, 75); push_exp(4, 100);
        test_run("ramp", 2, -1);
    endtask

    task automatic load_triangle();
        mem[0] = -16'sd8; mem[1] = 16'sd8; mem[2] = -16'sd8;
        exp_q.delete();
        push_exp(0, -8); push_exp(1, -4); push_exp(2, 0); push_exp(3, 4); push_exp(4, 8);
        push_exp(5, 4);  push_exp(6, 0);  push_exp(7, -4); push_exp(8, -8);
    endtask

    task automatic test_triangle();
        load_triangle();
        test_run("triangle", 3, -1);
    endtask

    task automatic test_extremes();
        mem[0] = 16'sd32767; mem[1] = -16'sd32768;
        exp_q.delete();
        push_exp(0, 32767); push_exp(1, 16383); push_exp(2, -1); push_exp(3, -16385); push_exp(4, -32768);
        test_run("extremes", 2, -1);
    endtask

    task automatic test_errors();
        logic [1:0] bad_mode [4] = '{2'b01, 2'b00, 2'b00, 2'b11};
        int         bad_n    [4] = '{4, 1, 257, 4};
        for (int c = 0; c < 4; c++) begin
            clear_obs();
            mode = bad_mode[c]; n_points = AW'(bad_n[c]); start = 1'b1;
            tick();
            start = 1'b0; mode = 2'b00;
            tick(); tick(); tick(); tick();
            checks++;
            if (err_cnt !== 1) begin errors++; $display("FAIL err_pulse case%0d: got %0d cycles want 1", c, err_cnt); end
            checks++;
            if (got_q.size() !== 0) begin errors++; $display("FAIL err_writes case%0d: got %0d want 0", c, got_q.size()); end
            checks++;
            if (busy_seen !== 0) begin errors++; $display("FAIL err_busy case%0d: got %0d busy cycles want 0", c, busy_seen); end
        end
    endtask

    task automatic test_abort();
        load_triangle();
        clear_obs();
        mode = 2'b00; n_points = AW'(3); start = 1'b1;
        tick();
        start = 1'b0;
        while (got_q.size() < 2 && cyc < 40) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++;
        if (out_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b want 0", out_we); end
        for (int k = 0; k < 30; k++) tick();
        checks++;
        if (got_q.size() !== 2) begin errors++; $display("FAIL abort_writes: got %0d want 2", got_q.size()); end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        checks++;
        if (got_q.size() < 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            errors++; $display("FAIL abort_partial: got %0d writes, first two differ from -8,-4", got_q.size());
        end
        test_run("after_abort", 3, -1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) mem[k] = DW'(k * 1000 - 1500);
        clear_obs();
        mode = 2'b00; n_points = AW'(4); start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, done, err, in_en, out_we, in_addr, out_addr, out_wdata} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b err=%b in_en=%b we=%b ia=%0d oa=%0d wd=%0d want all 0",
                     busy, done, err, in_en, out_we, in_addr, out_addr, out_wdata);
        end
        reset = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 30; k++) tick();
        checks++;
        if (done_cnt !== 0 || got_q.size() !== 0 || busy_seen !== 0) begin
            errors++; $display("FAIL midreset_abandon: got done=%0d writes=%0d busy=%0d want 0 0 0",
                               done_cnt, got_q.size(), busy_seen);
        end
    endtask

    task automatic test_busy_start();
        for (int k = 0; k < 6; k++) mem[k] = DW'($urandom);
        build_expected(6);
        test_run("busy_start", 6, 8);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 256; k++) mem[k] = DW'($urandom);
        build_expected(40);
        test_run("random40", 40, -1);
        build_expected(256);
        test_run("random256", 256, -1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_triangle();
        test_extremes();
        test_errors();
        test_abort();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
